bcd_timer: RTL and testbench
============================

# bcd_timer

Parametrised BCD timer core, the successor to the single-mode timer used in the timer top level. It holds a DIGITS-digit BCD value and can count down to zero with an alarm or count up as a stopwatch, at a tick rate set by a built-in prescaler. It takes raw pushbutton-level set/start inputs and drives the display module's `count` input and the board alarm output.

## Interface
- `DIGITS`, 4: number of BCD digits; value width is 4*DIGITS.
- `TICK_DIV`, 500000: clk cycles per count tick (5 MHz → 10 Hz); must be ≥ 2.
- `clk`  in  1  system clock (5 MHz clk5 domain).
- `rst`  in  1  reset; asynchronous, active-high.
- `set`  in  1  load request, level from button; rising edge acts.
- `start`  in  1  start/pause/acknowledge, level from button; rising edge acts.
- `mode`  in  1  0 = count down, 1 = count up; latched on IDLE→RUN.
- `preset`  in  4*DIGITS  BCD load value, digit 0 in bits [3:0].
- `Q`  out  4*DIGITS  current BCD value.
- `alarm`  out  1  high while in DONE.
- `running`  out  1  high while in RUN.

## Operation
- `set` and `start` each pass through a 2-flop synchroniser, then a rising-edge detector (one-cycle pulse). Debounce is upstream's responsibility.
- States: IDLE, RUN, PAUSE, DONE. All outputs registered.
- Reset (async): state IDLE, `Q`=0, `alarm`=0, `running`=0, prescaler=0, latched mode=0, synchroniser/edge flops=0.
- set pulse in IDLE, PAUSE or DONE: `Q` ← `preset` with any digit >9 replaced by 9; state → IDLE; prescaler cleared. set in RUN is ignored.
- start pulse:
  - IDLE → RUN. Latch `mode` and clear the prescaler. Exception: in count-down mode with `Q`=0, stay in IDLE.
  - RUN → PAUSE (prescaler held).
  - PAUSE → RUN (prescaler resumes from its held value; latched mode unchanged).
  - DONE → IDLE (`alarm` clears, `Q` unchanged).
- Simultaneous set and start pulses: set wins; start is discarded.
- Prescaler counts 0..TICK_DIV-1 only in RUN. The cycle at which it equals TICK_DIV-1 is a tick, and it wraps to 0 on that cycle.
- Tick, down mode: BCD decrement with ripple borrow (x0 → x-1 borrowing, 0 → 9). If the result is all zeros, state → DONE on the same edge.
- Tick, up mode: BCD increment with ripple carry (9 → 0 carrying). If the result is all nines, state → DONE on the same edge; there is no wrap to zero.
- In DONE: `Q` is frozen and `alarm`=1 until a start or set pulse.
- `mode` changes outside IDLE→RUN have no effect.

## Timing
- Button rising edge sampled at clk edge n: the edge pulse is valid after edge n+2, and the state/`Q` change is visible after edge n+3.
- First tick occurs TICK_DIV cycles after entering RUN from IDLE. Subsequent ticks follow every TICK_DIV cycles of RUN time; PAUSE time does not count.
- `Q` updates on the tick edge.
- `running`, `alarm` and state change on the same edge. In down mode, DONE, `alarm`=1 and `Q`=0 all become visible together.
- Reset mid-RUN: all outputs return to reset values immediately (asynchronously), and no tick is pending after release.

## Test plan
- Reset, then set with preset=0x0012, then start (DIGITS=4, TICK_DIV=4, mode=0): `Q` goes 0012→0011→…→0000 with one step per 4 clk. `alarm`=1 and `running`=0 on the edge where `Q` becomes 0000. A further start gives `alarm`=0, state IDLE.
- Borrow chain: preset 0x1000, down mode, 1 tick → `Q`=0999.
- Up mode from `Q`=0x9997: 9998, 9999, then DONE with `Q` held at 9999. `alarm`=1.
- Pause: start in RUN after 2 prescaler cycles, wait 20 clk, start again → next tick arrives exactly 2 cycles later, and `Q` is unchanged during PAUSE. set during RUN has no effect.
- Edge cases:
  - set and start rising on the same cycle in IDLE → `Q`=preset, state stays IDLE.
  - preset 0x00A0 loads as 0x0090.
  - start with `Q`=0 in down mode → stays IDLE.
- Assert `rst` mid-RUN between ticks: `Q`=0, `running`=0, `alarm`=0 immediately. After release and set/start, the first tick comes a full TICK_DIV later.

Source files
------------

// File: rtl/bcd_timer.sv
// BCD countdown/stopwatch timer: synchronised button edges, built-in tick prescaler,
// and a four-state controller that drives the display value and the alarm.
module bcd_timer #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 500000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set,
  input  logic                start,
  input  logic                mode,
  input  logic [4*DIGITS-1:0] preset,
  output logic [4*DIGITS-1:0] Q,
  output logic                alarm,
  output logic                running
);

  // state | meaning
  // IDLE  | holding Q, waiting for set/start
  // RUN   | prescaler advancing, Q steps on each tick
  // PAUSE | Q and prescaler frozen
  // DONE  | Q frozen at terminal value, alarm high

  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [W-1:0]  NINES    = {DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          mode_l;
  logic [1:0]    set_sync, start_sync;
  logic          set_d, start_d, set_p, start_p;
  logic [W-1:0]  q_inc, q_dec, q_load;

  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
        else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] >= 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    q_inc  = bcd_inc(Q);
    q_dec  = bcd_dec(Q);
    q_load = bcd_clamp(preset);
  end

  // Two-flop synchroniser followed by a registered rising-edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_sync   <= '0;
      start_sync <= '0;
      set_d      <= 1'b0;
      start_d    <= 1'b0;
      set_p      <= 1'b0;
      start_p    <= 1'b0;
    end else begin
      set_sync   <= {set_sync[0], set};
      start_sync <= {start_sync[0], start};
      set_d      <= set_sync[1];
      start_d    <= start_sync[1];
      set_p      <= set_sync[1] & ~set_d;
      start_p    <= start_sync[1] & ~start_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      Q       <= '0;
      alarm   <= 1'b0;
      running <= 1'b0;
      presc   <= '0;
      mode_l  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (set_p) begin
            Q     <= q_load;
            presc <= '0;
          end else if (start_p && (mode || Q != '0)) begin
            state   <= RUN;
            running <= 1'b1;
            mode_l  <= mode;
            presc   <= '0;
          end
        end
        RUN: begin
          // set is ignored here; a pause request wins over a coincident tick
          if (start_p) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (presc == PRE_LAST) begin
            presc <= '0;
            if (mode_l) begin
              if (Q != NINES) Q <= q_inc;
              if (Q == NINES || q_inc == NINES) begin
                state   <= DONE;
                running <= 1'b0;
                alarm   <= 1'b1;
              end
            end else begin
              Q <= q_dec;
              if (q_dec == '0) begin
                state   <= DONE;
                running <= 1'b0;
                alarm   <= 1'b1;
              end
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        PAUSE: begin
          if (set_p) begin
            Q     <= q_load;
            presc <= '0;
            state <= IDLE;
          end else if (start_p) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        DONE: begin
          if (set_p) begin
            Q     <= q_load;
            presc <= '0;
            state <= IDLE;
            alarm <= 1'b0;
          end else if (start_p) begin
            state <= IDLE;
            alarm <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_timer.sv
// Self-checking bench for bcd_timer: decimal-integer reference model compared every
// cycle, directed scenarios with literal expectations, then randomized button traffic.
module tb_bcd_timer;
  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 4;
  localparam int MAXV     = 9999;

  logic        clk = 1'b0;
  logic        rst, set, start, mode;
  logic [15:0] preset, Q;
  logic        alarm, running;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // reference model state: decimal value, 0=idle 1=run 2=pause 3=done
  int     m_val, m_state, m_el;
  bit     m_mode;
  bit [3:0] hs, ht;
  bit     sp, tp;

  always #5 clk = ~clk;

  bcd_timer #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst(rst), .set(set), .start(start), .mode(mode),
    .preset(preset), .Q(Q), .alarm(alarm), .running(running)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_dec(input logic [15:0] p);
    int v, m, d;
    v = 0;
    m = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'((p >> (4 * i)) & 16'hF);
      if (d > 9) d = 9;
      v += d * m;
      m *= 10;
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Buttons reach the controller three clock edges after being sampled.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_val = 0; m_state = 0; m_el = 0; m_mode = 1'b0; hs = '0; ht = '0;
    end else begin
      sp = hs[2] & ~hs[3];
      tp = ht[2] & ~ht[3];
      hs = {hs[2:0], set};
      ht = {ht[2:0], start};
      case (m_state)
        0: if (sp) begin m_val = clamp_dec(preset); m_el = 0; end
           else if (tp && (mode || m_val != 0)) begin m_state = 1; m_mode = mode; m_el = 0; end
        1: if (tp) m_state = 2;
           else begin
             m_el++;
             if (m_el == TICK_DIV) begin
               m_el = 0;
               if (m_mode) begin
                 if (m_val < MAXV) m_val++;
                 if (m_val == MAXV) m_state = 3;
               end else begin
                 m_val--;
                 if (m_val == 0) m_state = 3;
               end
             end
           end
        2: if (sp) begin m_val = clamp_dec(preset); m_el = 0; m_state = 0; end
           else if (tp) m_state = 1;
        3: if (sp) begin m_val = clamp_dec(preset); m_el = 0; m_state = 0; end
           else if (tp) m_state = 0;
        default: m_state = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("model_q", 32'(Q), 32'(to_bcd(m_val)));
      check("model_alarm", 32'(alarm), 32'(m_state == 3));
      check("model_running", 32'(running), 32'(m_state == 1));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_set(input logic [15:0] p);
    preset = p; set = 1'b1; cyc(1); set = 1'b0; cyc(3);
  endtask

  task automatic press_start();
    start = 1'b1; cyc(1); start = 1'b0; cyc(3);
  endtask

  task automatic press_both(input logic [15:0] p);
    preset = p; set = 1'b1; start = 1'b1; cyc(1); set = 1'b0; start = 1'b0; cyc(3);
  endtask

  task automatic wait_alarm(input int budget);
    int k;
    k = 0;
    while (!alarm && k < budget) begin cyc(1); k++; end
    if (!alarm) check("alarm_timeout", 32'(alarm), 32'd1);
  endtask

  task automatic wait_q_change(input logic [15:0] from, input int budget);
    int k;
    k = 0;
    while (Q === from && k < budget) begin cyc(1); k++; end
    if (Q === from) check("tick_timeout", 32'(Q), 32'(from) ^ 32'd1);
  endtask

  initial begin
    rst = 1'b1; set = 1'b0; start = 1'b0; mode = 1'b0; preset = '0;
    cyc(3);
    check("reset_q", 32'(Q), 32'h0);
    check("reset_alarm", 32'(alarm), 32'd0);
    check("reset_running", 32'(running), 32'd0);
    rst = 1'b0;
    cyc(1);
    cmp_en = 1'b1;

    // countdown from 12 to DONE, then acknowledge
    press_set(16'h0012);
    check("load_0012", 32'(Q), 32'h0012);
    press_start();
    check("run_started", 32'(running), 32'd1);
    wait_alarm(200);
    check("done_q", 32'(Q), 32'h0000);
    check("done_running", 32'(running), 32'd0);
    check("done_alarm", 32'(alarm), 32'd1);
    press_start();
    check("ack_alarm", 32'(alarm), 32'd0);
    check("ack_q", 32'(Q), 32'h0000);

    // ripple borrow, then set ignored while running
    press_set(16'h1000);
    press_start();
    cyc(4);
    check("borrow_0999", 32'(Q), 32'h0999);
    cyc(2);
    press_set(16'h0055);
    check("set_in_run_running", 32'(running), 32'd1);
    check("set_in_run_q", 32'(Q == 16'h0055), 32'd0);
    press_start();
    check("paused", 32'(running), 32'd0);

    // pause two prescaler cycles after a tick; resume finishes the period
    press_set(16'h0050);
    press_start();
    wait_q_change(16'h0050, 20);
    check("first_tick", 32'(Q), 32'h0049);
    cyc(3);
    press_start();
    check("pause_q", 32'(Q), 32'h0048);
    cyc(20);
    check("pause_hold_q", 32'(Q), 32'h0048);
    check("pause_running", 32'(running), 32'd0);
    press_start();
    cyc(1);
    check("resume_no_tick", 32'(Q), 32'h0048);
    cyc(1);
    check("resume_tick", 32'(Q), 32'h0047);

    // up mode to all nines; later mode changes are ignored
    press_start();
    press_set(16'h9997);
    mode = 1'b1;
    press_start();
    mode = 1'b0;
    wait_alarm(100);
    check("up_done_q", 32'(Q), 32'h9999);
    check("up_done_alarm", 32'(alarm), 32'd1);
    cyc(10);
    check("up_hold_q", 32'(Q), 32'h9999);
    press_start();

    press_set(16'h00A0);
    check("clamp_00a0", 32'(Q), 32'h0090);
    press_both(16'h0321);
    check("both_q", 32'(Q), 32'h0321);
    check("both_idle", 32'(running), 32'd0);
    press_set(16'h0000);
    mode = 1'b0;
    press_start();
    check("zero_start_idle", 32'(running), 32'd0);

    // asynchronous reset mid-run
    press_set(16'h0030);
    press_start();
    cyc(2);
    cmp_en = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_q", 32'(Q), 32'h0);
    check("async_rst_running", 32'(running), 32'd0);
    check("async_rst_alarm", 32'(alarm), 32'd0);
    @(negedge clk) rst = 1'b0;
    cyc(1);
    cmp_en = 1'b1;
    press_set(16'h0030);
    press_start();
    cyc(3);
    check("post_rst_no_tick", 32'(Q), 32'h0030);
    cyc(1);
    check("post_rst_tick", 32'(Q), 32'h0029);

    // randomized button traffic
    for (int i = 0; i < 2500; i++) begin
      set   = ($urandom_range(0, 15) == 0);
      start = ($urandom_range(0, 9) == 0);
      mode  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) preset = 16'($urandom_range(0, 15));
      else if ($urandom_range(0, 1) == 0) preset = 16'h9990 | 16'($urandom_range(0, 15));
      else preset = 16'($urandom);
      cyc(1);
    end
    set = 1'b0; start = 1'b0;
    cyc(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
